// File: rtl/gaplus_rom_port_arbiter_pkg.sv
// gaplus_rom_arb_pkg: states and helpers shared by the ROM port arbiter and its pick logic
package gaplus_rom_arb_pkg;
   typedef enum logic [1:0] {IDLE, READ, DLOAD} arb_state_t;
   localparam int MAX_RD_LAT = 7;
   function automatic int next_ptr(input int p, input int n);
      return (p == n - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/gaplus_rom_port_arbiter_if.sv
// gaplus_rom_port_arbiter_if: download, requester and memory-port signals of the ROM arbiter
interface gaplus_rom_port_arbiter_if #(
   parameter int AW   = 16,
   parameter int DW   = 8,
   parameter int NREQ = 3
);
   logic                 DLEN;
   logic                 DLWR;
   logic [AW-1:0]        DLAD;
   logic [DW-1:0]        DLDT;
   logic [NREQ-1:0]      REQ;
   logic [NREQ*AW-1:0]   RAD;
   logic [NREQ-1:0]      GNT;
   logic [NREQ-1:0]      VLD;
   logic [DW-1:0]        RDT;
   logic                 BUSY;
   logic [AW-1:0]        MAD;
   logic                 MRE;
   logic                 MWE;
   logic [DW-1:0]        MDO;
   logic [DW-1:0]        MDI;
   modport slave (
      input  DLEN, DLWR, DLAD, DLDT, REQ, RAD, MDI,
      output GNT, VLD, RDT, BUSY, MAD, MRE, MWE, MDO
   );
   modport master (
      output DLEN, DLWR, DLAD, DLDT, REQ, RAD, MDI,
      input  GNT, VLD, RDT, BUSY, MAD, MRE, MWE, MDO
   );
endinterface

// File: rtl/gaplus_rom_port_arbiter_rr_pick.sv
// gaplus_rr_pick: first set request at or after ptr, wrapping modulo NREQ
module gaplus_rr_pick #(
   parameter int NREQ = 3,
   localparam int PW  = $clog2(NREQ)
) (
   input  logic [PW-1:0]   ptr,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx,
   output logic            any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Walk from farthest to nearest so the nearest hit is the one left standing
      for (int k = NREQ - 1; k >= 0; k--) begin
         int j;
         j = int'(ptr) + k;
         j = (j >= NREQ) ? j - NREQ : j;
         if (req[j]) begin
            gnt = NREQ'(1) << j;
            idx = PW'(j);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/gaplus_rom_port_arbiter.sv
// gaplus_rom_port_arbiter: one ROM port shared by the HPS download stream (priority) and NREQ round-robin readers
module gaplus_rom_port_arbiter
   import gaplus_rom_arb_pkg::*;
#(
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int NREQ   = 3,
   parameter int RD_LAT = 2
) (
   input logic MCLK,
   input logic RESET,
   gaplus_rom_port_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_RD_LAT + 1);

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   rr_q, rr_d, g_q, g_d, pick_idx;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d, vld_q, vld_d, pick_gnt;
   logic [DW-1:0]   rdt_q, rdt_d, mdo_q, mdo_d;
   logic [AW-1:0]   mad_q, mad_d;
   logic            mre_q, mre_d, mwe_q, mwe_d, busy_q, busy_d, pick_any;

   gaplus_rr_pick #(.NREQ(NREQ)) u_pick (
      .ptr (rr_q),
      .req (bus.REQ),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      vld_d   = '0;
      rdt_d   = rdt_q;
      mad_d   = mad_q;
      mdo_d   = mdo_q;
      mre_d   = 1'b0;
      mwe_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.DLEN) begin
               state_d = DLOAD;
            end else if (pick_any) begin
               state_d = READ;
               g_d     = pick_idx;
               gnt_d   = pick_gnt;
               mad_d   = bus.RAD[pick_idx*AW +: AW];
               mre_d   = 1'b1;
               cnt_d   = CW'(RD_LAT);
            end
         end
         READ: begin
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               rdt_d   = bus.MDI;
               vld_d   = gnt_q;
               gnt_d   = '0;
               rr_d    = PW'(next_ptr(int'(g_q), NREQ));
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DLOAD: begin
            // The exit edge still forwards its strobe, so a byte written as DLEN falls is kept
            mwe_d = bus.DLWR;
            mad_d = bus.DLAD;
            mdo_d = bus.DLDT;
            if (!bus.DLEN) begin
               state_d = IDLE;
               rr_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         state_q <= IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         vld_q   <= '0;
         rdt_q   <= '0;
         mad_q   <= '0;
         mdo_q   <= '0;
         mre_q   <= 1'b0;
         mwe_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         rdt_q   <= rdt_d;
         mad_q   <= mad_d;
         mdo_q   <= mdo_d;
         mre_q   <= mre_d;
         mwe_q   <= mwe_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.VLD  = vld_q;
   assign bus.RDT  = rdt_q;
   assign bus.BUSY = busy_q;
   assign bus.MAD  = mad_q;
   assign bus.MRE  = mre_q;
   assign bus.MWE  = mwe_q;
   assign bus.MDO  = mdo_q;
endmodule

// File: tb/tb_gaplus_rom_port_arbiter.sv
// tb_gaplus_rom_port_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_gaplus_rom_port_arbiter;
   localparam int AW = 16, DW = 8, NREQ = 3, RD_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gaplus_rom_port_arbiter_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();
   gaplus_rom_port_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
      .MCLK  (clk),
      .RESET (rst),
      .bus   (bus)
   );

   int tests = 0, fails = 0, cyc = 0;
   int owner = -1, done_at = 0, rr = 0;
   bit dl = 1'b0;
   logic [NREQ-1:0] e_gnt = '0, e_vld = '0;
   logic [DW-1:0]   e_rdt = '0, e_mdo = '0;
   logic [AW-1:0]   e_mad = '0;
   logic            e_mre = 1'b0, e_mwe = 1'b0, e_busy = 1'b0;
   int grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // Model: a read owns the port from its grant cycle until grant+RD_LAT; downloads own it while DLEN holds
   task automatic model_edge();
      int pick;
      cyc++;
      e_vld = '0;
      e_mre = 1'b0;
      e_mwe = 1'b0;
      if (rst) begin
         owner = -1; dl = 1'b0; rr = 0;
         e_gnt = '0; e_rdt = '0; e_mad = '0; e_mdo = '0;
      end else if (owner >= 0) begin
         if (cyc == done_at) begin
            e_rdt = bus.MDI;
            e_vld = NREQ'(1) << owner;
            e_gnt = '0;
            rr    = (owner + 1) % NREQ;
            owner = -1;
         end
      end else if (dl) begin
         e_mwe = bus.DLWR;
         e_mad = bus.DLAD;
         e_mdo = bus.DLDT;
         if (!bus.DLEN) begin dl = 1'b0; rr = 0; end
      end else if (bus.DLEN) begin
         dl = 1'b1;
      end else if (bus.REQ != '0) begin
         pick = -1;
         for (int k = 0; k < NREQ; k++)
            if (pick < 0 && bus.REQ[(rr + k) % NREQ]) pick = (rr + k) % NREQ;
         owner   = pick;
         done_at = cyc + RD_LAT;
         e_gnt   = NREQ'(1) << pick;
         e_mad   = bus.RAD[pick*AW +: AW];
         e_mre   = 1'b1;
      end
      e_busy = (owner >= 0) || dl;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("gnt", 32'(bus.GNT), 32'(e_gnt));
      chk("vld", 32'(bus.VLD), 32'(e_vld));
      chk("rdt", 32'(bus.RDT), 32'(e_rdt));
      chk("mad", 32'(bus.MAD), 32'(e_mad));
      chk("mre", 32'(bus.MRE), 32'(e_mre));
      chk("mwe", 32'(bus.MWE), 32'(e_mwe));
      chk("mdo", 32'(bus.MDO), 32'(e_mdo));
      chk("busy", 32'(bus.BUSY), 32'(e_busy));
      if (bus.MRE)
         for (int i = 0; i < NREQ; i++) if (bus.GNT[i]) grants.push_back(i);
   endtask

   initial begin
      bus.DLEN = 1'b0; bus.DLWR = 1'b0; bus.DLAD = '0; bus.DLDT = '0;
      bus.REQ = '0; bus.RAD = '0; bus.MDI = '0;
      step(); step();
      chk("reset_gnt", 32'(bus.GNT), 32'h0);
      chk("reset_busy", 32'(bus.BUSY), 32'h0);
      rst = 1'b0;
      // Single read by requester 1
      bus.REQ = 3'b010;
      bus.RAD[1*AW +: AW] = 16'h1234;
      step();
      chk("t1_mre", 32'(bus.MRE), 32'h1);
      chk("t1_mad", 32'(bus.MAD), 32'h1234);
      step();
      chk("t1_mre_fall", 32'(bus.MRE), 32'h0);
      bus.MDI = 8'hA5;
      step();
      chk("t1_vld", 32'(bus.VLD), 32'h2);
      chk("t1_rdt", 32'(bus.RDT), 32'hA5);
      bus.REQ = '0;
      // A bare download pulse brings the pointer back to 0
      bus.DLEN = 1'b1; step();
      bus.DLEN = 1'b0; step();
      // Contention: all three requesters held for 12 cycles
      grants.delete();
      bus.REQ = 3'b111;
      repeat (12) begin
         bus.MDI = DW'($urandom);
         step();
      end
      bus.REQ = '0;
      chk("t2_ngrants", 32'(grants.size()), 32'd4);
      if (grants.size() == 4) begin
         chk("t2_g0", 32'(grants[0]), 32'd0);
         chk("t2_g1", 32'(grants[1]), 32'd1);
         chk("t2_g2", 32'(grants[2]), 32'd2);
         chk("t2_g3", 32'(grants[3]), 32'd0);
      end
      // Download arrives while requester 2 is reading
      bus.REQ = 3'b100;
      bus.RAD[2*AW +: AW] = 16'hBEEF;
      step();
      chk("t3_gnt", 32'(bus.GNT), 32'h4);
      bus.DLEN = 1'b1;
      step();
      bus.MDI = 8'h77;
      step();
      chk("t3_vld", 32'(bus.VLD), 32'h4);
      bus.REQ = 3'b001;
      step();
      bus.DLWR = 1'b1; bus.DLAD = 16'h0007; bus.DLDT = 8'h3C;
      step();
      chk("t3_mwe", 32'(bus.MWE), 32'h1);
      chk("t3_mad", 32'(bus.MAD), 32'h0007);
      chk("t3_mdo", 32'(bus.MDO), 32'h3C);
      bus.DLWR = 1'b0;
      step(); step();
      chk("t3_held", 32'(bus.GNT), 32'h0);
      // Download exit with a strobe in the falling cycle, REQ[2] pending
      bus.REQ = 3'b100;
      bus.DLWR = 1'b1; bus.DLAD = 16'h0008; bus.DLDT = 8'h5A; bus.DLEN = 1'b0;
      step();
      chk("t4_mwe", 32'(bus.MWE), 32'h1);
      chk("t4_mad", 32'(bus.MAD), 32'h0008);
      bus.DLWR = 1'b0;
      step();
      chk("t4_gnt", 32'(bus.GNT), 32'h4);
      chk("t4_mre", 32'(bus.MRE), 32'h1);
      bus.REQ = '0;
      step(); step();
      // Reset one cycle after a grant
      bus.REQ = 3'b001;
      bus.RAD[0*AW +: AW] = 16'h4321;
      step(); step();
      rst = 1'b1;
      step();
      chk("t5_gnt", 32'(bus.GNT), 32'h0);
      chk("t5_mad", 32'(bus.MAD), 32'h0);
      chk("t5_rdt", 32'(bus.RDT), 32'h0);
      rst = 1'b0;
      bus.REQ = '0;
      step();
      chk("t5_novld", 32'(bus.VLD), 32'h0);
      // Random traffic
      repeat (3000) begin
         if ($urandom_range(0, 39) == 0) bus.DLEN = ~bus.DLEN;
         bus.DLWR = bus.DLEN & 1'($urandom);
         bus.DLAD = AW'($urandom);
         bus.DLDT = DW'($urandom);
         if ($urandom_range(0, 3) == 0) bus.REQ = NREQ'($urandom);
         bus.RAD = (NREQ*AW)'({$urandom, $urandom});
         bus.MDI = DW'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
